// File: rtl/audio_voice_mixer_pkg.sv
// Shared definitions for the time-multiplexed voice mixer: waveform codes,
// FSM encoding, saturation limits and the 12-bit clamp helper.
package audio_voice_mixer_pkg;

    typedef enum logic [1:0] {
        WAVE_OFF      = 2'b00,
        WAVE_SQUARE   = 2'b01,
        WAVE_SAW      = 2'b10,
        WAVE_TRIANGLE = 2'b11
    } wave_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OUT  = 2'b10
    } state_e;

    localparam logic signed [13:0] SAT_MAX = 14'sd2047;
    localparam logic signed [13:0] SAT_MIN = -14'sd2048;
    localparam logic signed [11:0] SQ_AMP  = 12'sd2047;

    function automatic logic signed [11:0] sat12(input logic signed [13:0] x);
        logic signed [11:0] r;
        if (x > SAT_MAX) begin
            r = SAT_MAX[11:0];
        end else if (x < SAT_MIN) begin
            r = SAT_MIN[11:0];
        end else begin
            r = x[11:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_voice_mixer_if.sv
// Voice control inputs and mixed-sample output of the voice mixer.
interface audio_voice_mixer_if #(
    parameter int NUM_VOICES = 4
);
    import audio_voice_mixer_pkg::*;

    logic [16*NUM_VOICES-1:0] voice_freq;
    logic [2*NUM_VOICES-1:0]  voice_wave;
    logic [4*NUM_VOICES-1:0]  voice_vol;
    logic signed [11:0]       sample_out;
    logic                     sample_valid;

    modport master (
        output voice_freq, voice_wave, voice_vol,
        input  sample_out, sample_valid
    );

    modport slave (
        input  voice_freq, voice_wave, voice_vol,
        output sample_out, sample_valid
    );

endinterface

// File: rtl/audio_wave_gen.sv
// Combinational waveform generator: phase + waveform code + volume to a
// volume-scaled signed contribution, shared by all voices.
module audio_wave_gen
    import audio_voice_mixer_pkg::*;
(
    input  logic [23:0]        i_acc,
    input  logic [1:0]         i_wave,
    input  logic [3:0]         i_vol,
    output logic signed [12:0] o_contrib
);

    logic signed [11:0] w_wave;
    logic signed [16:0] w_prod;
    logic [10:0]        w_tri;

    // Raw waveform; saw and triangle subtract 2048 by inverting the MSB.
    always_comb begin
        w_wave = 12'sd0;
        w_tri  = i_acc[23] ? ~i_acc[22:12] : i_acc[22:12];
        case (i_wave)
            WAVE_SQUARE:   w_wave = i_acc[23] ? -SQ_AMP : SQ_AMP;
            WAVE_SAW:      w_wave = {~i_acc[23], i_acc[22:12]};
            WAVE_TRIANGLE: w_wave = {~w_tri[10], w_tri[9:0], 1'b0};
            default:       w_wave = 12'sd0;
        endcase
        w_prod    = $signed({{5{w_wave[11]}}, w_wave}) * $signed({13'd0, i_vol});
        o_contrib = w_prod[16:4];
    end

endmodule

// File: rtl/audio_voice_mixer.sv
// Time-multiplexed NUM_VOICES oscillator mixer: once per CLK_DIV cycles each
// voice is stepped in turn and the scaled sum is published as one sample.
module audio_voice_mixer
    import audio_voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int CLK_DIV    = 500
) (
    input  logic                clk,
    input  logic                resetn,
    audio_voice_mixer_if.slave  bus
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    if (NUM_VOICES < 1 || NUM_VOICES > 4) begin : g_bad_voices
        $error("audio_voice_mixer: NUM_VOICES must be 1..4");
    end
    if (CLK_DIV < NUM_VOICES + 3) begin : g_bad_div
        $error("audio_voice_mixer: CLK_DIV must be >= NUM_VOICES+3");
    end

    logic [CNT_W-1:0]   r_div;
    logic               w_tick;
    state_e             r_state;
    state_e             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic signed [13:0] r_mix;
    logic [23:0]        r_acc [NUM_VOICES];
    logic signed [11:0] r_sample;
    logic               r_valid;

    logic [15:0]        w_freq_v [NUM_VOICES];
    logic [1:0]         w_wave_v [NUM_VOICES];
    logic [3:0]         w_vol_v  [NUM_VOICES];
    logic [15:0]        w_freq;
    logic [1:0]         w_wave;
    logic [3:0]         w_vol;
    logic [23:0]        w_acc;
    logic signed [12:0] w_contrib;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign w_freq_v[v] = bus.voice_freq[16*v +: 16];
        assign w_wave_v[v] = bus.voice_wave[2*v +: 2];
        assign w_vol_v[v]  = bus.voice_vol[4*v +: 4];
    end

    assign w_freq = w_freq_v[r_idx];
    assign w_wave = w_wave_v[r_idx];
    assign w_vol  = w_vol_v[r_idx];
    assign w_acc  = r_acc[r_idx];
    assign w_tick = (r_div == CNT_W'(CLK_DIV - 1));

    audio_wave_gen u_wave_gen (
        .i_acc     (w_acc),
        .i_wave    (w_wave),
        .i_vol     (w_vol),
        .o_contrib (w_contrib)
    );

    // Free-running sample-rate divider.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_idx == IDX_W'(NUM_VOICES - 1)) begin
                    w_state_nxt = ST_OUT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_OUT:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Voice stepping, mix accumulation and registered sample output.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_idx    <= '0;
            r_mix    <= 14'sd0;
            r_sample <= 12'sd0;
            r_valid  <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_acc[v] <= 24'd0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_idx <= '0;
                        r_mix <= 14'sd0;
                    end
                end
                ST_RUN: begin
                    r_mix <= r_mix + {w_contrib[12], w_contrib};
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_wave == WAVE_OFF) begin
                        r_acc[r_idx] <= 24'd0;
                    end else begin
                        r_acc[r_idx] <= w_acc + {8'd0, w_freq};
                    end
                end
                ST_OUT: begin
                    r_sample <= sat12(r_mix >>> 1);
                    r_valid  <= 1'b1;
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign bus.sample_out   = r_sample;
    assign bus.sample_valid = r_valid;

endmodule

// File: tb/tb_audio_voice_mixer.sv
// Self-checking bench for audio_voice_mixer against an arithmetic reference
// model of the oscillators and mixing rules.
module tb_audio_voice_mixer;

    localparam int NV = 4;
    localparam int CD = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    int tb_freq [NV];
    int tb_wave [NV];
    int tb_vol  [NV];
    int m_acc   [NV];

    audio_voice_mixer_if #(.NUM_VOICES(NV)) bus ();

    audio_voice_mixer #(.NUM_VOICES(NV), .CLK_DIV(CD)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic apply_inputs();
        for (int v = 0; v < NV; v++) begin
            bus.voice_freq[16*v +: 16] = tb_freq[v][15:0];
            bus.voice_wave[2*v +: 2]   = tb_wave[v][1:0];
            bus.voice_vol[4*v +: 4]    = tb_vol[v][3:0];
        end
    endtask

    task automatic set_voice(input int v, input int wave, input int freq, input int vol);
        tb_wave[v] = wave;
        tb_freq[v] = freq;
        tb_vol[v]  = vol;
        apply_inputs();
    endtask

    task automatic all_off();
        for (int v = 0; v < NV; v++) begin
            tb_wave[v] = 0; tb_freq[v] = 0; tb_vol[v] = 0;
        end
        apply_inputs();
    endtask

    // Reference: one output sample from the documented waveform/mix rules.
    function automatic int model_sample();
        int mix, w, c, lo, t, o;
        mix = 0;
        for (int v = 0; v < NV; v++) begin
            w = 0;
            case (tb_wave[v])
                1: w = (m_acc[v] >= 32'h80_0000) ? -2047 : 2047;
                2: w = (m_acc[v] / 4096) - 2048;
                3: begin
                    lo = (m_acc[v] / 4096) % 2048;
                    t  = (m_acc[v] >= 32'h80_0000) ? (2047 - lo) : lo;
                    w  = 2 * t - 2048;
                end
                default: w = 0;
            endcase
            c = (w * tb_vol[v]) >>> 4;
            mix += c;
            if (tb_wave[v] == 0) m_acc[v] = 0;
            else m_acc[v] = (m_acc[v] + tb_freq[v]) % 32'h100_0000;
        end
        o = mix >>> 1;
        if (o > 2047) o = 2047;
        if (o < -2048) o = -2048;
        return o;
    endfunction

    task automatic wait_valid(output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 3 * CD; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        for (int v = 0; v < NV; v++) m_acc[v] = 0;
    endtask

    task automatic test_reset();
        bit ok; int cyc, exp;
        all_off();
        set_voice(0, 2, 16'h1000, 15);
        resetn = 1'b0;
        repeat (4) @(posedge clk); #1;
        checks++;
        if (bus.sample_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%b exp=0", bus.sample_valid);
        end
        checks++;
        if (bus.sample_out !== 12'sd0) begin
            errors++; $display("FAIL reset_sample got=%0d exp=0", bus.sample_out);
        end
        resetn = 1'b1;
        for (int v = 0; v < NV; v++) m_acc[v] = 0;
        wait_valid(ok, cyc);
        checks++;
        if (!ok || cyc + 1 != CD + NV + 2) begin
            errors++; $display("FAIL first_latency got=%0d exp=%0d ok=%0d", cyc + 1, CD + NV + 2, ok);
        end
        exp = model_sample();
        checks++;
        if (bus.sample_out !== -12'sd960 || exp != -960) begin
            errors++; $display("FAIL saw_first got=%0d exp=-960 model=%0d", bus.sample_out, exp);
        end
        for (int i = 0; i < 3; i++) begin
            wait_valid(ok, cyc);
            exp = model_sample();
            checks++;
            if (!ok || cyc != CD || bus.sample_out !== 12'(exp)) begin
                errors++; $display("FAIL saw_period got=%0d/%0d exp=%0d/%0d", cyc, bus.sample_out, CD, exp);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (bus.sample_valid !== 1'b0) begin
            errors++; $display("FAIL strobe_width got=%b exp=0", bus.sample_valid);
        end
    endtask

    task automatic test_square();
        bit ok; int cyc, exp;
        all_off();
        set_voice(0, 1, 16'h8000, 15);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            wait_valid(ok, cyc);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL square_timeout sample=%0d", i); return;
            end
            exp = model_sample();
            if (bus.sample_out !== 12'(exp)) begin
                errors++; $display("FAIL square_model i=%0d got=%0d exp=%0d", i, bus.sample_out, exp);
            end
            if (i == 0 || i == 255 || i == 256 || i == 511 || i == 512) begin
                checks++;
                if (bus.sample_out !== ((i / 256) % 2 == 0 ? 12'sd959 : -12'sd960)) begin
                    errors++; $display("FAIL square_level i=%0d got=%0d", i, bus.sample_out);
                end
            end
        end
    endtask

    task automatic test_saturation();
        bit ok; int cyc, exp;
        for (int v = 0; v < NV; v++) set_voice(v, 1, 0, 15);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wait_valid(ok, cyc);
            exp = model_sample();
            checks++;
            if (!ok || bus.sample_out !== 12'sd2047 || exp != 2047) begin
                errors++; $display("FAIL sat_pos i=%0d got=%0d exp=2047 model=%0d", i, bus.sample_out, exp);
            end
        end
        for (int v = 0; v < NV; v++) set_voice(v, 1, 16'h8000, 15);
        for (int i = 0; i < 300; i++) begin
            wait_valid(ok, cyc);
            exp = model_sample();
            checks++;
            if (!ok || bus.sample_out !== 12'(exp)) begin
                errors++; $display("FAIL sat_model i=%0d got=%0d exp=%0d", i, bus.sample_out, exp);
            end
            if (i == 256) begin
                checks++;
                if (bus.sample_out !== -12'sd2048) begin
                    errors++; $display("FAIL sat_neg got=%0d exp=-2048", bus.sample_out);
                end
            end
        end
    endtask

    task automatic test_off_restart();
        bit ok; int cyc, exp;
        set_voice(0, 0, 16'h8000, 15);
        set_voice(1, 0, 16'h2222, 7);
        set_voice(2, 1, 16'h1234, 0);
        set_voice(3, 3, 16'h0777, 0);
        for (int i = 0; i < 20; i++) begin
            wait_valid(ok, cyc);
            exp = model_sample();
            checks++;
            if (!ok || bus.sample_out !== 12'sd0 || exp != 0) begin
                errors++; $display("FAIL silent i=%0d got=%0d exp=0", i, bus.sample_out);
            end
        end
        set_voice(0, 1, 16'h8000, 15);
        wait_valid(ok, cyc);
        exp = model_sample();
        checks++;
        if (!ok || bus.sample_out !== 12'sd959 || exp != 959) begin
            errors++; $display("FAIL restart got=%0d exp=959", bus.sample_out);
        end
    endtask

    task automatic test_triangle();
        bit ok; int cyc, exp, mx, mn;
        all_off();
        set_voice(0, 3, 16'h4000, 15);
        do_reset();
        mx = -99999; mn = 99999;
        for (int i = 0; i < 1100; i++) begin
            wait_valid(ok, cyc);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL tri_timeout sample=%0d", i); return;
            end
            exp = model_sample();
            if (bus.sample_out !== 12'(exp)) begin
                errors++; $display("FAIL tri_model i=%0d got=%0d exp=%0d", i, bus.sample_out, exp);
            end
            if (int'(bus.sample_out) > mx) mx = int'(bus.sample_out);
            if (int'(bus.sample_out) < mn) mn = int'(bus.sample_out);
        end
        checks++;
        if (mx != 959 || mn != -960) begin
            errors++; $display("FAIL tri_peaks got=%0d/%0d exp=959/-960", mx, mn);
        end
    endtask

    task automatic test_random();
        bit ok; int cyc, exp;
        for (int i = 0; i < 200; i++) begin
            if (i % 4 == 0) begin
                for (int v = 0; v < NV; v++) begin
                    set_voice(v, int'($urandom_range(0, 3)),
                              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 65535)),
                              int'($urandom_range(0, 15)));
                end
            end
            wait_valid(ok, cyc);
            exp = model_sample();
            checks++;
            if (!ok || bus.sample_out !== 12'(exp)) begin
                errors++; $display("FAIL random i=%0d got=%0d exp=%0d", i, bus.sample_out, exp);
            end
        end
    endtask

    task automatic test_midframe_reset();
        bit ok; int cyc, exp, seen;
        all_off();
        set_voice(0, 2, 16'h1000, 15);
        set_voice(1, 1, 16'h3000, 9);
        wait_valid(ok, cyc);
        repeat (CD - 4) @(posedge clk);
        #1 resetn = 1'b0;
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.sample_valid) seen++;
        end
        checks++;
        if (seen != 0 || bus.sample_out !== 12'sd0) begin
            errors++; $display("FAIL midframe_abort strobes=%0d sample=%0d exp=0/0", seen, bus.sample_out);
        end
        resetn = 1'b1;
        for (int v = 0; v < NV; v++) m_acc[v] = 0;
        wait_valid(ok, cyc);
        exp = model_sample();
        checks++;
        if (!ok || cyc + 1 != CD + NV + 2 || bus.sample_out !== 12'(exp)) begin
            errors++; $display("FAIL midframe_restart lat=%0d exp=%0d got=%0d exp=%0d",
                               cyc + 1, CD + NV + 2, bus.sample_out, exp);
        end
    endtask

    initial begin
        all_off();
        test_reset();
        test_square();
        test_saturation();
        test_off_restart();
        test_triangle();
        test_random();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
